soc_event_receiver: RTL

//  Consumer end of the SoC event stream (valid/ready + EVNT_WIDTH event ID) driven by the SoC event generator.

---
 rtl/soc_event_receiver_if.sv | 35 +++
 rtl/soc_event_receiver.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/soc_event_receiver_if.sv
// soc_event_receiver_if
//   Bundles the APB slave port and the incoming event stream of one event
//   receiver instance.
//   master : driven by the bus/event source (APB bridge + event generator)
//   slave  : the event receiver itself
//   Signals: PADDR/PWDATA/PWRITE/PSEL/PENABLE (APB request), PRDATA/PREADY/
//   PSLVERR (APB response), event_valid_i/event_data_i/event_ready_o (event
//   handshake), irq_o (level interrupt towards the core).
interface soc_event_receiver_if #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int EVNT_WIDTH     = 8
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;
  logic                      event_valid_i;
  logic [EVNT_WIDTH-1:0]     event_data_i;
  logic                      event_ready_o;
  logic                      irq_o;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE, event_valid_i, event_data_i,
    input  PRDATA, PREADY, PSLVERR, event_ready_o, irq_o
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE, event_valid_i, event_data_i,
    output PRDATA, PREADY, PSLVERR, event_ready_o, irq_o
  );
endinterface

// File: rtl/soc_event_receiver.sv
// soc_event_receiver
//   Consumer end of the SoC event stream. Incoming event IDs are buffered in a
//   FIFO; a level interrupt is raised while events are pending and the core
//   pops events, reads status and manages overflow through APB.
//   Ports:
//     HCLK    clock
//     HRESET  synchronous active-high reset
//     bus     slave side of soc_event_receiver_if (APB + event stream + irq)
//   Register map (PADDR[3:2]): 0 STATUS, 1 POP, 2 CTRL, 3 CLEAR.
//   Offsets above 0xC are unmapped: PSLVERR on access, no effect, read 0.
module soc_event_receiver #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int EVNT_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int DROP_ON_FULL   = 0
) (
  input logic              HCLK,
  input logic              HRESET,
  soc_event_receiver_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic DROP = (DROP_ON_FULL != 0);

  logic [EVNT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  enable;
  logic                  irq_en;
  logic                  overflow;
  logic [7:0]            drop_cnt;
  logic                  irq_q;

  logic       access;
  logic       mapped;
  logic [1:0] offset;
  logic       empty;
  logic       full;
  logic       pop;
  logic       wr_ctrl;
  logic       wr_clear;
  logic       flush;
  logic       clr_ovf;
  logic       ready;
  logic       accepted;
  logic       push;
  logic       drop;
  logic [EVNT_WIDTH-1:0] head;

  logic unused_bits;
  assign unused_bits = ^{bus.PADDR[1:0], bus.PWDATA[31:2]};

  assign access   = bus.PSEL & bus.PENABLE;
  assign offset   = bus.PADDR[3:2];
  assign mapped   = (bus.PADDR[APB_ADDR_WIDTH-1:4] == '0);
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign head     = mem[rd_ptr];

  // A POP read only pops when something is buffered.
  assign pop      = access & ~bus.PWRITE & mapped & (offset == 2'd1) & ~empty;
  assign wr_ctrl  = access & bus.PWRITE & mapped & (offset == 2'd2);
  assign wr_clear = access & bus.PWRITE & mapped & (offset == 2'd3);
  assign flush    = wr_clear & bus.PWDATA[0];
  assign clr_ovf  = wr_clear & bus.PWDATA[1];

  // A same-cycle pop frees a slot, so a full FIFO can still take an event.
  assign ready    = ~full | ~enable | DROP | pop;
  assign accepted = bus.event_valid_i & ready;
  assign push     = accepted & enable & (~full | pop);
  assign drop     = accepted & enable & full & ~pop;

  assign bus.event_ready_o = ready;
  assign bus.PREADY        = 1'b1;
  assign bus.PSLVERR       = access & ~mapped;
  assign bus.irq_o         = irq_q;

  // Occupancy after this edge; flush overrides any push/pop.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push & ~pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop & ~push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Read data is decoded combinationally; a same-cycle flush still shows the old head.
  always_comb begin
    bus.PRDATA = '0;
    if (mapped) begin
      case (offset)
        2'd0: bus.PRDATA = {drop_cnt, 7'b0, overflow, 8'(count), 6'b0, full, empty};
        2'd1: if (!empty) bus.PRDATA = {1'b1, {(31-EVNT_WIDTH){1'b0}}, head};
        2'd2: bus.PRDATA = {30'b0, irq_en, enable};
        default: bus.PRDATA = '0;
      endcase
    end
  end

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.event_data_i;
    end
  end

  // Control and status state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
      irq_q    <= 1'b0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_ctrl) begin
        enable <= bus.PWDATA[0];
        irq_en <= bus.PWDATA[1];
      end
      // A drop in the same cycle as a clear restarts the counter at 1.
      if (drop) begin
        overflow <= 1'b1;
        if (clr_ovf)                drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= 8'd0;
      end
      irq_q <= irq_en & (count_next != '0);
    end
  end

endmodule
